// File: rtl/lvds_tx_bus_ctrl.sv
// Round-robin arbiter and frame sequencer for a shared half-duplex tri-state LVDS driver.
// Each grant drives: guard low, start bit, LSB-first payload, stop bit, then guarded high-Z release.
module lvds_tx_bus_ctrl #(
    parameter int DATA_W    = 8,
    parameter int GUARD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_i,
    input  logic [DATA_W-1:0] din0_i,
    input  logic [DATA_W-1:0] din1_i,
    input  logic              hold_i,
    output logic [1:0]        gnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              tx_i_o,
    output logic              tx_t_o
);

    localparam int CNT_MAX = (GUARD_CYC > DATA_W) ? GUARD_CYC : DATA_W;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ENABLE,
        START,
        DATA,
        STOP,
        RELEASE
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              rr_q;
    logic [1:0]        gnt_q;
    logic              busy_q;
    logic              done_q;
    logic              tx_i_q;
    logic              tx_t_q;
    logic              win_d;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        win_d = rr_q;
        if (req_i == 2'b01) begin
            win_d = 1'b0;
        end else if (req_i == 2'b10) begin
            win_d = 1'b1;
        end
    end

    // NOTE: every state register uses non-blocking assignment so all of them update
    // together from the same pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rr_q    <= 1'b0;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_i_q  <= 1'b0;
            tx_t_q  <= 1'b1;
        end else begin
            gnt_q  <= 2'b00;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!hold_i && (req_i != 2'b00)) begin
                        gnt_q   <= win_d ? 2'b10 : 2'b01;
                        shift_q <= win_d ? din1_i : din0_i;
                        rr_q    <= ~win_d;
                        busy_q  <= 1'b1;
                        tx_t_q  <= 1'b0;
                        tx_i_q  <= 1'b0;
                        cnt_q   <= CW'(GUARD_CYC - 1);
                        state_q <= ENABLE;
                    end
                end
                ENABLE: begin
                    if (cnt_q == '0) begin
                        tx_i_q  <= 1'b1;
                        state_q <= START;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                START: begin
                    tx_i_q  <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    cnt_q   <= CW'(DATA_W - 1);
                    state_q <= DATA;
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        tx_i_q  <= 1'b0;
                        state_q <= STOP;
                    end else begin
                        tx_i_q  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        cnt_q   <= cnt_q - CW'(1);
                    end
                end
                STOP: begin
                    tx_t_q  <= 1'b1;
                    tx_i_q  <= 1'b0;
                    done_q  <= 1'b1;
                    cnt_q   <= CW'(GUARD_CYC - 1);
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    tx_t_q  <= 1'b1;
                    tx_i_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign tx_i_o = tx_i_q;
    assign tx_t_o = tx_t_q;

endmodule

// File: tb/tb_lvds_tx_bus_ctrl.sv
// Self-checking bench for lvds_tx_bus_ctrl: expected per-cycle output records are queued
// when a request is driven and popped against the DUT on each falling edge.
module tb_lvds_tx_bus_ctrl;

    localparam int G = 2;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] din0, din1;
    logic         hold;
    logic [1:0]   gnt;
    logic         busy, done, tx_i, tx_t;

    logic [1:0]   s_req;
    logic [0:0]   s_din0, s_din1;
    logic         s_hold;
    logic [1:0]   s_gnt;
    logic         s_busy, s_done, s_tx_i, s_tx_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Record format: {gnt[1:0], busy, done, tx_t, tx_i}
    logic [5:0] sb[$];

    typedef struct {
        logic [1:0]   req;
        logic [W-1:0] din0;
        logic [W-1:0] din1;
        logic         win;
        logic [W-1:0] data;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    lvds_tx_bus_ctrl #(.DATA_W(W), .GUARD_CYC(G)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .din0_i (din0),
        .din1_i (din1),
        .hold_i (hold),
        .gnt_o  (gnt),
        .busy_o (busy),
        .done_o (done),
        .tx_i_o (tx_i),
        .tx_t_o (tx_t)
    );

    lvds_tx_bus_ctrl #(.DATA_W(1), .GUARD_CYC(1)) u_small (
        .clk    (clk),
        .rst    (rst),
        .req_i  (s_req),
        .din0_i (s_din0),
        .din1_i (s_din1),
        .hold_i (s_hold),
        .gnt_o  (s_gnt),
        .busy_o (s_busy),
        .done_o (s_done),
        .tx_i_o (s_tx_i),
        .tx_t_o (s_tx_t)
    );

    function automatic logic [5:0] act_main();
        return {gnt, busy, done, tx_t, tx_i};
    endfunction

    function automatic logic [5:0] act_small();
        return {s_gnt, s_busy, s_done, s_tx_t, s_tx_i};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected waveform of one frame plus the idle cycle that follows it.
    task automatic push_frame(input logic win, input logic [W-1:0] data);
        sb.push_back({(win ? 2'b10 : 2'b01), 4'b1_0_0_0});
        for (int g = 1; g < G; g++) sb.push_back(6'b00_1_0_0_0);
        sb.push_back(6'b00_1_0_0_1);
        for (int k = 0; k < W; k++) sb.push_back({5'b00_1_0_0, data[k]});
        sb.push_back(6'b00_1_0_0_0);
        sb.push_back(6'b00_1_1_1_0);
        for (int g = 1; g < G; g++) sb.push_back(6'b00_1_0_1_0);
        sb.push_back(6'b00_0_0_1_0);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) sb.push_back(6'b00_0_0_1_0);
    endtask

    task automatic drain(input string name, input bit drop_req, input int hold_idx);
        int idx;
        logic [5:0] exp;
        idx = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            exp = sb.pop_front();
            check(name, 32'(act_main()), 32'(exp));
            if (drop_req && idx == 0) req = 2'b00;
            if (idx == hold_idx) hold = 1'b1;
            idx++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] small_exp[6];
        logic [5:0] exp;
        int gnt_cnt, done_cnt, aborted;
        bit in_frame;

        vecs[0] = '{req: 2'b01, din0: 8'hA5, din1: 8'h00, win: 1'b0, data: 8'hA5};
        vecs[1] = '{req: 2'b10, din0: 8'h00, din1: 8'h3C, win: 1'b1, data: 8'h3C};
        vecs[2] = '{req: 2'b11, din0: 8'h5A, din1: 8'hC3, win: 1'b0, data: 8'h5A};
        vecs[3] = '{req: 2'b11, din0: 8'hF0, din1: 8'h0F, win: 1'b1, data: 8'h0F};
        vecs[4] = '{req: 2'b10, din0: 8'h11, din1: 8'hFF, win: 1'b1, data: 8'hFF};
        vecs[5] = '{req: 2'b11, din0: 8'h00, din1: 8'h81, win: 1'b0, data: 8'h00};

        small_exp[0] = 6'b01_1_0_0_0;
        small_exp[1] = 6'b00_1_0_0_1;
        small_exp[2] = 6'b00_1_0_0_1;
        small_exp[3] = 6'b00_1_0_0_0;
        small_exp[4] = 6'b00_1_1_1_0;
        small_exp[5] = 6'b00_0_0_1_0;

        rst = 1'b1; req = 2'b00; din0 = '0; din1 = '0; hold = 1'b0;
        s_req = 2'b00; s_din0 = 1'b0; s_din1 = 1'b0; s_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(act_main()), 32'(6'b00_0_0_1_0));
        check("reset_state_small", 32'(act_small()), 32'(6'b00_0_0_1_0));
        rst = 1'b0;

        // Table of single-frame transactions, rr pointer carried across entries.
        for (int v = 0; v < 6; v++) begin
            req  = vecs[v].req;
            din0 = vecs[v].din0;
            din1 = vecs[v].din1;
            push_frame(vecs[v].win, vecs[v].data);
            drain($sformatf("vec%0d", v), 1'b1, -1);
        end

        // Reset mid-DATA: outputs fall back immediately, no DONE afterwards.
        req = 2'b01; din0 = 8'hA5;
        push_frame(1'b0, 8'hA5);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            check("pre_abort", 32'(act_main()), 32'(exp));
            if (k == 0) req = 2'b00;
        end
        rst = 1'b1;
        #1;
        check("reset_mid_frame", 32'(act_main()), 32'(6'b00_0_0_1_0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        push_idle(16);
        drain("post_abort_idle", 1'b0, -1);

        // Contention from reset: alternating grants every 15 cycles.
        rst = 1'b1; req = 2'b11; din0 = 8'h01; din1 = 8'h80;
        @(negedge clk);
        rst = 1'b0;
        push_frame(1'b0, 8'h01);
        push_frame(1'b1, 8'h80);
        push_frame(1'b0, 8'h01);
        push_frame(1'b1, 8'h80);
        drain("contention", 1'b0, -1);
        req = 2'b00;

        // HOLD blocks grants in IDLE; HOLD raised mid-DATA has no effect.
        req = 2'b10; din1 = 8'h96; hold = 1'b1;
        push_idle(20);
        drain("hold_idle", 1'b0, -1);
        hold = 1'b0;
        push_frame(1'b1, 8'h96);
        drain("hold_mid_frame", 1'b1, 6);
        hold = 1'b0;

        // Random REQ/HOLD/RST with invariant checks and grant/done accounting.
        gnt_cnt = 0; done_cnt = 0; aborted = 0; in_frame = 1'b0;
        for (int c = 0; c < 2020; c++) begin
            @(negedge clk);
            check("inv_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("inv_tx_t_drive", 32'(tx_t || (busy && !done)), 32'd1);
            if (gnt != 2'b00) begin
                gnt_cnt++;
                in_frame = 1'b1;
            end
            if (done) begin
                done_cnt++;
                in_frame = 1'b0;
            end
            if (c < 2000) begin
                req  = 2'($urandom_range(0, 3));
                hold = ($urandom_range(0, 9) < 3);
                din0 = 8'($urandom);
                din1 = 8'($urandom);
                if (rst) begin
                    rst = 1'b0;
                end else if ($urandom_range(0, 99) == 0) begin
                    rst = 1'b1;
                    if (in_frame) begin
                        aborted++;
                        in_frame = 1'b0;
                    end
                end
            end else begin
                req = 2'b00; hold = 1'b0; rst = 1'b0;
            end
        end
        check("done_count", 32'(done_cnt), 32'(gnt_cnt - aborted));

        // DATA_W=1, GUARD_CYC=1 instance: 0,1,1,0 driven, then one release cycle.
        s_req = 2'b01; s_din0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("small_cycle%0d", k), 32'(act_small()), 32'(small_exp[k]));
            s_req = 2'b00;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
